ssdec_scan: RTL and testbench

// - Time-multiplexed driver for NUM_DIGITS hex seven-segment digits sharing one segment bus.
// - Cycles a one-hot digit select and drives the decoded hex glyph of the selected digit.
// - Sits between the door-lock controller (code entry / status nibbles) and the board display pins.
// - Double-buffered: new values apply only at frame start, so a digit never shows a half-updated frame.

---
 rtl/ssdec_scan.sv | 186 ++++++++++++++++++
 tb/tb_ssdec_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ssdec_scan.sv
// Time-multiplexed hex seven-segment scanner with a frame-synchronous double buffer.
// Optional blinking is compiled in with `define SSDEC_BLINK_EN.
module ssdec_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 256
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    fs_q, fs_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic                    tc;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   lit;
  logic [6:0]              dig_seg [NUM_DIGITS];

  always_comb begin
    tc   = (presc_q == PRESC_LAST);
    wrap = tc && (idx_q == IDX_LAST);
  end

  // Per-digit glyph after blanking; the scan just picks one of these.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign dig_seg[gi] = lit[gi] ? glyph(act_digits_q[4*gi +: 4]) : 7'h00;
  end

`ifdef SSDEC_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d;
  logic [NUM_DIGITS-1:0] act_blink_q, act_blink_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;

  always_comb begin
    sh_blink_d  = sh_blink_q;
    act_blink_d = act_blink_q;
    fcnt_d      = fcnt_q;
    phase_d     = phase_q;
    if (wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    // Same buffering rules as dig_en so blink changes are frame aligned too.
    if (wrap && load) begin
      act_blink_d = blink;
    end else if (wrap && pending_q) begin
      act_blink_d = sh_blink_q;
    end else if (load) begin
      sh_blink_d = blink;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sh_blink_q  <= '0;
      act_blink_q <= '0;
      fcnt_q      <= '0;
      phase_q     <= 1'b0;
    end else begin
      sh_blink_q  <= sh_blink_d;
      act_blink_q <= act_blink_d;
      fcnt_q      <= fcnt_d;
      phase_q     <= phase_d;
    end
  end

  assign lit = act_en_q & ~({NUM_DIGITS{phase_q}} & act_blink_q);
`else
  logic unused_blink;
  assign unused_blink = ^blink;
  assign lit = act_en_q;
`endif

  always_comb begin
    presc_d      = presc_q + 1'b1;
    idx_d        = idx_q;
    pending_d    = pending_q;
    sh_digits_d  = sh_digits_q;
    sh_en_d      = sh_en_q;
    act_digits_d = act_digits_q;
    act_en_d     = act_en_q;
    if (tc) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Registered so the pulse lines up with the cycle in which wrap is true.
    fs_d = (presc_d == PRESC_LAST) && (idx_d == IDX_LAST);
    if (wrap && load) begin
      act_digits_d = digits;
      act_en_d     = dig_en;
      pending_d    = 1'b0;
    end else if (wrap && pending_q) begin
      act_digits_d = sh_digits_q;
      act_en_d     = sh_en_q;
      pending_d    = 1'b0;
    end else if (load) begin
      sh_digits_d = digits;
      sh_en_d     = dig_en;
      pending_d   = 1'b1;
    end
    seg_d = dig_seg[idx_q];
    an_d  = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      fs_q         <= 1'b0;
      seg_q        <= '0;
      an_q         <= '0;
      pending_q    <= 1'b0;
      sh_digits_q  <= '0;
      sh_en_q      <= '0;
      act_digits_q <= '0;
      act_en_q     <= '0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      fs_q         <= fs_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      pending_q    <= pending_d;
      sh_digits_q  <= sh_digits_d;
      sh_en_q      <= sh_en_d;
      act_digits_q <= act_digits_d;
      act_en_q     <= act_en_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_ssdec_scan.sv
// Directed bench for ssdec_scan with NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2 (16-cycle frames).
module tb_ssdec_scan;

  logic        clk = 1'b0;
  logic        nrst;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dig_en;
  logic [3:0]  blink;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int k = 0;  // clock edges since the last reset release

  ssdec_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .nrst(nrst), .load(load), .digits(digits), .dig_en(dig_en),
    .blink(blink), .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [15:0]     digits;
    logic [3:0]      en;
    logic [3:0][6:0] exp_seg;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end else begin
      $display("ok   %s: %0h (k=%0d)", name, act, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Advance to the cycle whose position in the 16-cycle frame is r.
  task automatic goto(input int r);
    do step(); while (k % 16 != r);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] b);
    load = 1'b1; digits = d; dig_en = e; blink = b;
    step();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit blink_build;
`ifdef SSDEC_BLINK_EN
    blink_build = 1'b1;
`else
    blink_build = 1'b0;
`endif
    vecs[0] = '{"hex3A71", 16'h3A71, 4'hF,    {7'h4F, 7'h77, 7'h07, 7'h06}};
    vecs[1] = '{"blank2",  16'h8888, 4'b1011, {7'h7F, 7'h00, 7'h7F, 7'h7F}};
    vecs[2] = '{"hexFEDC", 16'hFEDC, 4'hF,    {7'h71, 7'h79, 7'h5E, 7'h39}};
    vecs[3] = '{"hex6420", 16'h6420, 4'hF,    {7'h7D, 7'h66, 7'h5B, 7'h3F}};
    vecs[4] = '{"hexB985", 16'hB985, 4'hF,    {7'h7C, 7'h6F, 7'h7F, 7'h6D}};

    nrst = 1'b0; load = 1'b0; digits = '0; dig_en = '0; blink = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_seg", 32'(seg), 32'h0);
    chk("reset_an", 32'(an), 32'h0);
    chk("reset_fs", 32'(frame_start), 32'h0);
    nrst = 1'b1;
    k = 0;

    // Unloaded walk: each digit held 4 cycles, all blank, pulse on the wrap cycle.
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("walk_an", 32'(an), 32'(4'b0001 << (((k - 1) / 4) % 4)));
      chk("walk_seg", 32'(seg), 32'h0);
      chk("walk_fs", 32'(frame_start), 32'((k % 16) == 15));
    end

    foreach (vecs[v]) begin
      goto(6);
      do_load(vecs[v].digits, vecs[v].en, 4'h0);
      goto(0);
      for (int j = 0; j < 4; j++) begin
        goto(4 * j + 2);
        chk({vecs[v].name, "_an"}, 32'(an), 32'(4'b0001 << j));
        chk({vecs[v].name, "_seg"}, 32'(seg), 32'(vecs[v].exp_seg[j]));
      end
    end

    // Two mid-frame loads: current frame keeps B985, next frame shows the last load.
    goto(8);
    do_load(16'h0005, 4'hF, 4'h0);
    goto(10);
    chk("midload_d2_seg", 32'(seg), 32'h6F);
    goto(12);
    do_load(16'h0009, 4'hF, 4'h0);
    goto(14);
    chk("midload_d3_seg", 32'(seg), 32'h7C);
    goto(2);
    chk("lastwins_d0_an", 32'(an), 32'h1);
    chk("lastwins_d0_seg", 32'(seg), 32'h6F);
    goto(6);
    chk("lastwins_d1_seg", 32'(seg), 32'h3F);

    // Load in the frame-start cycle takes effect in the frame that follows immediately.
    goto(15);
    chk("fs_cycle", 32'(frame_start), 32'h1);
    do_load(16'h000E, 4'hF, 4'h0);
    chk("fs_after", 32'(frame_start), 32'h0);
    goto(2);
    chk("fsload_d0_seg", 32'(seg), 32'h79);

    // Blink on digit 0: phase flips every second frame when the feature is built.
    goto(6);
    do_load(16'h0001, 4'hF, 4'b0001);
    for (int f = 0; f < 4; f++) begin
      int w;
      goto(0);
      w = k / 16;
      goto(2);
      chk("blink_d0_seg", 32'(seg),
          (blink_build && ((w / 2) % 2 == 1)) ? 32'h00 : 32'h06);
      goto(6);
      chk("blink_d1_seg", 32'(seg), 32'h3F);
    end

    // Asynchronous reset mid-hold on digit 1, then a clean restart, all blank.
    goto(5);
    chk("prerst_an", 32'(an), 32'h2);
    chk("prerst_seg", 32'(seg), 32'h3F);
    #2;
    nrst = 1'b0;
    #1;
    chk("asyncrst_seg", 32'(seg), 32'h0);
    chk("asyncrst_an", 32'(an), 32'h0);
    chk("asyncrst_fs", 32'(frame_start), 32'h0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    k = 0;
    step();
    chk("restart_an", 32'(an), 32'h1);
    chk("restart_seg", 32'(seg), 32'h0);
    goto(5);
    chk("restart_d1_an", 32'(an), 32'h2);
    chk("restart_d1_seg", 32'(seg), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
